// File: rtl/approx_pipelined_dadda_multiplier.sv
// Three-stage unsigned WIDTH x WIDTH multiplier. Partial products are Dadda-reduced to two rows.
// In approximate mode the low APPROX_COLS product columns are dropped before reduction.
module approx_pipelined_dadda_multiplier #(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 4,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    input  logic               approx_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out,
    output logic               out_approx,
    output logic [CNT_W-1:0]   approx_count
);
    localparam int PW = 2 * WIDTH;

    // Handshake: a request is taken when in_valid && in_ready, a product leaves when
    // out_valid && out_ready. A held output freezes every stage, so in_ready = !stall.
    logic stall;
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    logic             s1_valid, s1_approx;
    logic [WIDTH-1:0] s1_a, s1_b;
    logic             s2_valid, s2_approx;
    logic [PW-1:0]    s2_row_a, s2_row_b;
    logic [PW-1:0]    row_a, row_b;

    // Dadda height limits 2, 3, 4, 6, 9, 13, 19 ...
    function automatic int dadda_limit(input int step);
        int d;
        d = 2;
        for (int k = 0; k < step; k++) d = (d * 3) / 2;
        return d;
    endfunction

    always_comb begin : reduce
        logic [WIDTH:0] col [PW];
        logic [WIDTH:0] nxt [PW];
        int             hgt [PW];
        int             nh  [PW];
        int             total, idx, d;
        logic           s, cy;
        total = 0;
        idx   = 0;
        d     = 0;
        s     = 1'b0;
        cy    = 1'b0;
        for (int c = 0; c < PW; c++) begin
            col[c] = '0;
            nxt[c] = '0;
            hgt[c] = 0;
            nh[c]  = 0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                col[i+j][hgt[i+j]] = s1_a[i] & s1_b[j] & !(s1_approx && (i + j < APPROX_COLS));
                hgt[i+j] = hgt[i+j] + 1;
            end
        end
        for (int st = 6; st >= 0; st--) begin
            d = dadda_limit(st);
            if (d < WIDTH) begin
                for (int c = 0; c < PW; c++) begin
                    nxt[c] = '0;
                    nh[c]  = 0;
                end
                // Columns are walked LSB first so carries land before their column is counted.
                for (int c = 0; c < PW; c++) begin
                    total = hgt[c] + nh[c];
                    idx   = 0;
                    for (int k = 0; k < WIDTH; k++) begin
                        if (total > d) begin
                            if (total == d + 1) begin
                                s     = col[c][idx] ^ col[c][idx+1];
                                cy    = col[c][idx] & col[c][idx+1];
                                idx   = idx + 2;
                                total = total - 1;
                            end else begin
                                s     = col[c][idx] ^ col[c][idx+1] ^ col[c][idx+2];
                                cy    = (col[c][idx] & col[c][idx+1]) |
                                        (col[c][idx] & col[c][idx+2]) |
                                        (col[c][idx+1] & col[c][idx+2]);
                                idx   = idx + 3;
                                total = total - 2;
                            end
                            nxt[c][nh[c]] = s;
                            nh[c] = nh[c] + 1;
                            if (c + 1 < PW) begin
                                nxt[c+1][nh[c+1]] = cy;
                                nh[c+1] = nh[c+1] + 1;
                            end
                        end
                    end
                    for (int k = 0; k <= WIDTH; k++) begin
                        if (k >= idx && k < hgt[c]) begin
                            nxt[c][nh[c]] = col[c][k];
                            nh[c] = nh[c] + 1;
                        end
                    end
                end
                for (int c = 0; c < PW; c++) begin
                    col[c] = nxt[c];
                    hgt[c] = nh[c];
                end
            end
        end
        for (int c = 0; c < PW; c++) begin
            row_a[c] = col[c][0];
            row_b[c] = col[c][1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid     <= 1'b0;
            s1_approx    <= 1'b0;
            s1_a         <= '0;
            s1_b         <= '0;
            s2_valid     <= 1'b0;
            s2_approx    <= 1'b0;
            s2_row_a     <= '0;
            s2_row_b     <= '0;
            out_valid    <= 1'b0;
            out          <= '0;
            out_approx   <= 1'b0;
            approx_count <= '0;
        end else begin
            if (!stall) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_a      <= in1;
                    s1_b      <= in2;
                    s1_approx <= approx_en;
                end
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_row_a  <= row_a;
                    s2_row_b  <= row_b;
                    s2_approx <= s1_approx;
                end
                out_valid <= s2_valid;
                if (s2_valid) begin
                    out        <= s2_row_a + s2_row_b;
                    out_approx <= s2_approx;
                end
            end
            if (out_valid && out_ready && out_approx && (approx_count != '1)) begin
                approx_count <= approx_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_approx_pipelined_dadda_multiplier.sv
// Randomised and directed bench for the approximate Dadda multiplier against a bit-sum model.
module tb_approx_pipelined_dadda_multiplier;
    localparam int WIDTH = 8;
    localparam int AC    = 4;
    localparam int CNT_W = 4;
    localparam int PW    = 2 * WIDTH;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in1 = '0;
    logic [WIDTH-1:0] in2 = '0;
    logic             approx_en = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [PW-1:0]    out;
    logic             out_approx;
    logic [CNT_W-1:0] approx_count;

    int checks = 0;
    int errors = 0;

    logic [PW:0]      exp_q[$];
    logic [CNT_W-1:0] exp_cnt = '0;
    int               out_seen = 0;
    logic             prev_stall = 1'b0;
    logic [PW:0]      prev_out;

    approx_pipelined_dadda_multiplier #(.WIDTH(WIDTH), .APPROX_COLS(AC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .approx_en(approx_en),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .out_approx(out_approx), .approx_count(approx_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Product as a sum of bit weights, skipping the dropped columns in approximate mode.
    function automatic logic [PW-1:0] ref_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic ap);
        logic [PW-1:0] acc;
        acc = '0;
        for (int i = 0; i < WIDTH; i++)
            for (int j = 0; j < WIDTH; j++)
                if (a[i] && b[j] && !(ap && (i + j < AC))) acc = acc + (PW'(1) << (i + j));
        return acc;
    endfunction

    // Scoreboard: inputs change only just after posedge, so negedge sees settled handshakes.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            check("in_ready_rule", in_ready, !(out_valid && !out_ready));
            check("approx_count", approx_count, exp_cnt);
            if (prev_stall) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_data", {out_approx, out}, prev_out);
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_approx, out};
            if (in_valid && in_ready) exp_q.push_back({approx_en, ref_mul(in1, in2, approx_en)});
            if (out_valid && out_ready) begin
                out_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1'b1, 1'b0);
                end else begin
                    check("product", {out_approx, out}, exp_q.pop_front());
                    if (out_approx && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
                end
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ap);
        logic acc;
        in_valid  = 1'b1;
        in1       = a;
        in2       = b;
        approx_en = ap;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        check("send_timeout", 1'b1, 1'b0);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 30 && exp_q.size() != 0; n++) @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Single request into an empty pipe; cycles counted from the cycle the request is presented.
    task automatic run_one(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ap,
                           input logic [PW-1:0] exp_out, input logic [CNT_W-1:0] exp_count);
        int n;
        n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in1       = a;
        in2       = b;
        approx_en = ap;
        while (n < 10) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            n++;
            if (out_valid) break;
        end
        check("latency", n, 3);
        check("directed_out", out, exp_out);
        check("directed_approx", out_approx, ap);
        @(posedge clk);
        #1;
        check("directed_count", approx_count, exp_count);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out", out, 0);
        check("rst_count", approx_count, 0);
        exp_q.delete();
        exp_cnt   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out", out, 0);
        check("reset_out_approx", out_approx, 1'b0);
        check("reset_count", approx_count, 0);
        check("reset_in_ready", in_ready, 1'b1);

        run_one(8'd255, 8'd255, 1'b0, 16'hFE01, 4'd0);
        run_one(8'd255, 8'd255, 1'b1, 16'hFDD0, 4'd1);

        // Back-to-back stream; results must come out on consecutive cycles.
        send(8'd3, 8'd5, 1'b0);
        send(8'd200, 8'd100, 1'b1);
        send(8'd0, 8'd255, 1'b0);
        for (int n = 0; n < 10 && !out_valid; n++) @(negedge clk);
        for (int n = 0; n < 3; n++) begin
            check("stream_back_to_back", out_valid, 1'b1);
            @(negedge clk);
        end
        drain();

        // Backpressure in the middle of a 5-request stream.
        out_seen = 0;
        fork
            for (int k = 0; k < 5; k++) send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("backpressure_count", out_seen, 5);

        // Reset with work in flight, then a clean request.
        out_ready = 1'b0;
        send(8'd17, 8'd33, 1'b1);
        send(8'd91, 8'd7, 1'b0);
        send(8'd250, 8'd3, 1'b1);
        do_reset();
        run_one(8'd12, 8'd13, 1'b0, 16'd156, 4'd0);

        // Random traffic with random backpressure.
        for (int k = 0; k < 2000; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in1       = WIDTH'($urandom);
            in2       = WIDTH'($urandom);
            approx_en = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        drain();

        // Counter saturation with exact requests interleaved.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            send(WIDTH'($urandom), WIDTH'($urandom), 1'b1);
            send(WIDTH'($urandom), WIDTH'($urandom), 1'b0);
        end
        drain();
        repeat (2) @(posedge clk);
        #1;
        check("saturated_count", approx_count, 4'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d expected=0", 1);
        $fatal(1, "timeout");
    end
endmodule
